// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the PWM bank.
package pwm_pkg;

  localparam int unsigned RATIO_W_DEF    = 8;
  localparam int unsigned PRESCALE_W_DEF = 16;
  localparam int unsigned RATIO_FULL_DEF = (1 << RATIO_W_DEF) - 1;

  // How a channel's active ratio moves at a period boundary.
  typedef enum logic [1:0] {
    SLEW_OFF  = 2'd0,
    SLEW_SNAP = 2'd1,
    SLEW_UP   = 2'd2,
    SLEW_DOWN = 2'd3
  } slew_e;

  // Full-scale ratio (period length in ticks) for a given ratio width.
  function automatic int unsigned ratio_full(input int unsigned w);
    return (1 << w) - 1;
  endfunction

  // Bits needed to index n channels.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: target/active ratio, slew limiting, output register, done pulse.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned RATIO_W = RATIO_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_wr,
  input  logic [RATIO_W-1:0] i_wr_data,
  input  logic               i_enable,
  input  logic               i_boundary,
  input  logic [RATIO_W-1:0] i_count,
  input  logic [RATIO_W-1:0] i_slew_step,
  output logic               o_pwm,
  output logic               o_done
);

  logic [RATIO_W-1:0] r_target;
  logic [RATIO_W-1:0] r_active;
  logic               r_pwm;
  logic               r_done;
  logic [RATIO_W-1:0] w_diff;
  logic [RATIO_W-1:0] w_next;
  slew_e              w_mode;

  // Decide how the active ratio moves at the next boundary.
  always_comb begin
    w_diff = (r_target >= r_active) ? (r_target - r_active) : (r_active - r_target);
    if (!i_enable)
      w_mode = SLEW_OFF;
    else if ((i_slew_step == '0) || (w_diff <= i_slew_step))
      w_mode = SLEW_SNAP;
    else if (r_target > r_active)
      w_mode = SLEW_UP;
    else
      w_mode = SLEW_DOWN;
  end

  // Candidate active ratio; a step never overshoots since |diff| > step here.
  always_comb begin
    w_next = r_active;
    case (w_mode)
      SLEW_OFF:  w_next = '0;
      SLEW_SNAP: w_next = r_target;
      SLEW_UP:   w_next = r_active + i_slew_step;
      SLEW_DOWN: w_next = r_active - i_slew_step;
      default:   w_next = r_active;
    endcase
  end

  // Target capture, boundary-only active update, registered output and done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_target <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (i_wr)
        r_target <= i_wr_data;
      if (i_boundary)
        r_active <= w_next;
      r_done <= i_boundary && (w_mode == SLEW_SNAP) && (r_target != r_active);
      r_pwm  <= i_enable && (i_count < r_active);
    end
  end

  assign o_pwm  = r_pwm;
  assign o_done = r_done;

endmodule

// File: rtl/pwm_bank.sv
// N-channel PWM bank: shared prescaler and period counter, write decode, per-channel slices.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH     = 12,
  parameter int unsigned RATIO_W    = RATIO_W_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [RATIO_W-1:0]    wr_data,
  input  logic [NUM_CH-1:0]     ch_enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [RATIO_W-1:0]    slew_step,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  period_start,
  output logic [NUM_CH-1:0]     update_done
);

  localparam logic [RATIO_W-1:0] CNT_LAST = RATIO_W'(ratio_full(RATIO_W) - 1);

  logic [PRESCALE_W-1:0] r_presc;
  logic [RATIO_W-1:0]    r_count;
  logic                  r_period_start;
  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_boundary;
  logic [NUM_CH-1:0]     w_wr_sel;

  // Tick and boundary; >= lets a lowered prescale take effect without wrapping.
  always_comb begin
    w_tick     = (r_presc >= prescale);
    w_wrap     = (r_count == CNT_LAST);
    w_boundary = w_tick && w_wrap;
  end

  // Prescaler, period counter and period-start pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc        <= '0;
      r_count        <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : (r_presc + PRESCALE_W'(1));
      if (w_tick)
        r_count <= w_wrap ? '0 : (r_count + RATIO_W'(1));
      r_period_start <= w_boundary;
    end
  end

  // Write decode; out-of-range addresses match no channel.
  always_comb begin
    w_wr_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      w_wr_sel[i] = wr_en && (wr_addr == ADDR_W'(i));
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(.RATIO_W(RATIO_W)) u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_wr        (w_wr_sel[g]),
      .i_wr_data   (wr_data),
      .i_enable    (ch_enable[g]),
      .i_boundary  (w_boundary),
      .i_count     (r_count),
      .i_slew_step (slew_step),
      .o_pwm       (pwm_out[g]),
      .o_done      (update_done[g])
    );
  end

  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: table vectors, directed corner sequences, random run vs model.
module tb_pwm_bank;

  localparam int NUM_CH = 12;
  localparam int RATIO_W = 8;
  localparam int PRESCALE_W = 16;
  localparam int ADDR_W = 5;
  localparam int PER = 255;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [RATIO_W-1:0]    wr_data;
  logic [NUM_CH-1:0]     ch_enable;
  logic [PRESCALE_W-1:0] prescale;
  logic [RATIO_W-1:0]    slew_step;
  logic [NUM_CH-1:0]     pwm_out;
  logic                  period_start;
  logic [NUM_CH-1:0]     update_done;

  pwm_bank #(
    .NUM_CH(NUM_CH), .RATIO_W(RATIO_W), .PRESCALE_W(PRESCALE_W), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ch_enable(ch_enable), .prescale(prescale),
    .slew_step(slew_step), .pwm_out(pwm_out), .period_start(period_start),
    .update_done(update_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: time is the number of clock edges since reset release;
  // the counter value follows arithmetically from the tick rate.
  int mk, mp;
  int m_target[NUM_CH];
  int m_active[NUM_CH];
  logic [NUM_CH-1:0] e_pwm, e_done;
  logic e_ps;

  int hi[NUM_CH];
  int dn[NUM_CH];
  int ps_cnt, ps_pos, win_steps;

  typedef struct {
    int addr; int data; int slew; int meas_ch; int exp_high; int exp_done;
  } vec_t;
  vec_t tbl[12];
  int ramp[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int p);
    mk = 0;
    mp = p;
    for (int i = 0; i < NUM_CH; i++) begin
      m_target[i] = 0;
      m_active[i] = 0;
    end
  endtask

  task automatic model_edge();
    int cnt_prev, old, nw, t, diff, s;
    bit tick, bnd;
    mk++;
    tick = (mk % (mp + 1)) == 0;
    cnt_prev = ((mk - 1) / (mp + 1)) % PER;
    bnd = tick && (cnt_prev == PER - 1);
    s = int'(slew_step);
    e_ps = bnd;
    e_done = '0;
    for (int i = 0; i < NUM_CH; i++)
      e_pwm[i] = ch_enable[i] && (cnt_prev < m_active[i]);
    if (bnd) begin
      for (int i = 0; i < NUM_CH; i++) begin
        old = m_active[i];
        t = m_target[i];
        diff = (t > old) ? t - old : old - t;
        if (!ch_enable[i]) nw = 0;
        else if (s == 0 || diff <= s) nw = t;
        else if (t > old) nw = old + s;
        else nw = old - s;
        e_done[i] = ch_enable[i] && (nw != old) && (nw == t);
        m_active[i] = nw;
      end
    end
    if (wr_en && int'(wr_addr) < NUM_CH)
      m_target[int'(wr_addr)] = int'(wr_data);
  endtask

  task automatic clear_win();
    for (int i = 0; i < NUM_CH; i++) begin
      hi[i] = 0;
      dn[i] = 0;
    end
    ps_cnt = 0;
    ps_pos = 0;
    win_steps = 0;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("pwm_out", int'(pwm_out), int'(e_pwm));
    check("period_start", int'(period_start), int'(e_ps));
    check("update_done", int'(update_done), int'(e_done));
    win_steps++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pwm_out[i]) hi[i]++;
      if (update_done[i]) dn[i]++;
    end
    if (period_start) begin
      ps_cnt++;
      ps_pos = win_steps;
    end
  endtask

  task automatic wait_ps(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!period_start && n < budget);
    check("period_start_seen", int'(period_start), 1);
  endtask

  task automatic window(input int len);
    clear_win();
    repeat (len) step();
  endtask

  task automatic write(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = RATIO_W'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset(input int p);
    reset_n = 1'b0;
    wr_en = 1'b0;
    prescale = PRESCALE_W'(p);
    repeat (3) @(posedge clock);
    #1;
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_period_start", int'(period_start), 0);
    check("reset_update_done", int'(update_done), 0);
    reset_n = 1'b1;
    model_reset(p);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{addr: 0,  data: 128, slew: 0,   meas_ch: 0, exp_high: 128, exp_done: 1};
    tbl[1]  = '{addr: 1,  data: 0,   slew: 0,   meas_ch: 1, exp_high: 0,   exp_done: 0};
    tbl[2]  = '{addr: 2,  data: 255, slew: 0,   meas_ch: 2, exp_high: 255, exp_done: 1};
    tbl[3]  = '{addr: 6,  data: 60,  slew: 100, meas_ch: 6, exp_high: 60,  exp_done: 1};
    tbl[4]  = '{addr: 6,  data: 20,  slew: 30,  meas_ch: 6, exp_high: 30,  exp_done: 0};
    tbl[5]  = '{addr: 6,  data: 20,  slew: 30,  meas_ch: 6, exp_high: 20,  exp_done: 0};
    tbl[6]  = '{addr: 7,  data: 255, slew: 255, meas_ch: 7, exp_high: 255, exp_done: 1};
    tbl[7]  = '{addr: 7,  data: 0,   slew: 0,   meas_ch: 7, exp_high: 0,   exp_done: 1};
    tbl[8]  = '{addr: 16, data: 77,  slew: 0,   meas_ch: 0, exp_high: 128, exp_done: 0};
    tbl[9]  = '{addr: 17, data: 99,  slew: 0,   meas_ch: 1, exp_high: 0,   exp_done: 0};
    tbl[10] = '{addr: 8,  data: 1,   slew: 0,   meas_ch: 8, exp_high: 1,   exp_done: 1};
    tbl[11] = '{addr: 9,  data: 254, slew: 0,   meas_ch: 9, exp_high: 254, exp_done: 1};
    ramp = '{32, 64, 96, 128, 160, 192, 200};

    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    ch_enable = '1;
    slew_step = '0;
    prescale = '0;
    reset_n = 1'b0;
    #12;
    do_reset(0);

    // Table: write a target, let one boundary apply it, measure the next period.
    for (int v = 0; v < 12; v++) begin
      slew_step = RATIO_W'(tbl[v].slew);
      clear_win();
      write(tbl[v].addr, tbl[v].data);
      wait_ps(2 * PER);
      check($sformatf("vec%0d_done", v), dn[tbl[v].meas_ch], tbl[v].exp_done);
      window(PER);
      check($sformatf("vec%0d_high", v), hi[tbl[v].meas_ch], tbl[v].exp_high);
      check($sformatf("vec%0d_period", v), ps_pos, PER);
    end

    // Slew ramp on ch3: 0 -> 200 in steps of 32.
    slew_step = 8'd32;
    write(3, 200);
    wait_ps(2 * PER);
    check("ramp_first_done", int'(update_done[3]), 0);
    for (int j = 0; j < 7; j++) begin
      window(PER);
      check($sformatf("ramp%0d_high", j), hi[3], ramp[j]);
      check($sformatf("ramp%0d_done", j), int'(update_done[3]), (j == 5) ? 1 : 0);
    end

    // Write landing on the boundary clock applies one period later.
    slew_step = '0;
    write(4, 40);
    wait_ps(2 * PER);
    repeat (PER - 1) step();
    wr_en = 1'b1;
    wr_addr = 5'd4;
    wr_data = 8'd100;
    step();
    wr_en = 1'b0;
    check("bwrite_on_boundary", int'(period_start), 1);
    window(PER);
    check("bwrite_old_ratio", hi[4], 40);
    window(PER);
    check("bwrite_new_ratio", hi[4], 100);

    // Disable mid-pulse, then soft-start on re-enable.
    write(5, 150);
    wait_ps(2 * PER);
    repeat (10) step();
    check("dis_high_before", int'(pwm_out[5]), 1);
    ch_enable[5] = 1'b0;
    step();
    check("dis_low_next_clock", int'(pwm_out[5]), 0);
    wait_ps(2 * PER);
    repeat (20) step();
    slew_step = 8'd50;
    ch_enable[5] = 1'b1;
    wait_ps(2 * PER);
    for (int j = 0; j < 3; j++) begin
      window(PER);
      check($sformatf("soft%0d_high", j), hi[5], 50 * (j + 1));
    end

    // Prescale 3: 1020-clock period.
    slew_step = '0;
    do_reset(3);
    write(0, 128);
    wait_ps(5 * 1020);
    window(1020);
    check("presc_period", ps_pos, 1020);
    check("presc_ps_count", ps_cnt, 1);
    check("presc_high", hi[0], 512);

    // Asynchronous reset mid-period.
    write(2, 255);
    wait_ps(3 * 1020);
    repeat (9) step();
    check("async_pre_high", int'(pwm_out[2]), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_pwm_out", int'(pwm_out), 0);
    check("async_period_start", int'(period_start), 0);
    check("async_update_done", int'(update_done), 0);
    do_reset(0);
    clear_win();
    write(0, 200);
    wait_ps(2 * PER);
    check("post_reset_first_boundary", win_steps, PER);
    check("post_reset_active_zero", hi[0], 0);

    // Random traffic against the model.
    do_reset(int'($urandom_range(0, 1)));
    ch_enable = NUM_CH'($urandom);
    slew_step = RATIO_W'($urandom_range(0, 60));
    repeat (6000) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        wr_en = 1'b1;
        wr_addr = ADDR_W'($urandom_range(0, 31));
        wr_data = RATIO_W'($urandom_range(0, 255));
      end else if (r == 3) begin
        ch_enable[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      end else if (r == 4) begin
        slew_step = RATIO_W'($urandom_range(0, 80));
      end
      step();
      wr_en = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
Parametrised N-channel PWM generator. It replaces the per-motor single-channel pwm instances with one block that has a shared timebase, per-channel target registers and per-channel slew (soft-start) limiting. It sits between the address decoder (register writes) and the motor/servo pins. All channels update synchronously at the period boundary, so there are no glitched or runt pulses.

Parameters:
NUM_CH, 12, number of PWM channels (1..32)
RATIO_W, 8, ratio/counter width; a period is 2^RATIO_W-1 ticks
PRESCALE_W, 16, width of the tick prescaler value
ADDR_W, 5, width of the channel-select address (must satisfy 2^ADDR_W >= NUM_CH)

Ports:
clock  in  1  main clock
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  one-cycle write strobe for a channel target ratio
wr_addr  in  ADDR_W  channel index for the write
wr_data  in  RATIO_W  target high-time, out of 2^RATIO_W-1
ch_enable  in  NUM_CH  per-channel enable
prescale  in  PRESCALE_W  a tick occurs every prescale+1 clocks
slew_step  in  RATIO_W  maximum change of the active ratio per period; 0 = immediate
pwm_out  out  NUM_CH  registered PWM outputs
period_start  out  1  one-cycle pulse on the first tick of each period
update_done  out  NUM_CH  one-cycle pulse when a channel's active ratio reaches its target

Behaviour:
- Reset (asynchronous, active-low) clears: prescaler, period counter, all targets, all active ratios, pwm_out, period_start and update_done, all to 0.
- Prescaler: counts clocks 0..prescale. It emits a tick and returns to 0 when count >= prescale. The >= comparison means lowering prescale mid-count takes effect without a wrap.
- Period counter: advances on each tick over 0..2^RATIO_W-2, then wraps to 0. The boundary is the tick on which the counter wraps to 0. period_start pulses for one clock, in the clock after that tick.
- Target write: when wr_en=1 and wr_addr<NUM_CH, target[wr_addr] <= wr_data. Writes with wr_addr>=NUM_CH are ignored. Targets are never applied mid-period.
- Active-ratio update happens at the boundary only, per channel:
  - ch_enable=0: active <= 0 and no update_done pulse.
  - slew_step=0 or |target-active| <= slew_step: active <= target.
  - otherwise: active moves toward target by exactly slew_step.
- update_done[i] pulses in the same clock as period_start when, at this boundary, active[i] changed and the new value equals target[i].
- A write on the same clock as a boundary is not seen by that boundary. The boundary uses the old target; the new one applies at the next boundary.
- Output: pwm_out[i] <= ch_enable[i] & (count < active[i]), registered, so there is 1 clock of latency from the counter.
  - ratio 0 gives a constant low output.
  - ratio 2^RATIO_W-1 gives a constant high output (100%).
- Enable deassert: pwm_out[i] goes low on the next clock, regardless of period phase. On re-enable the channel soft-starts from active=0, ramping by slew_step per period.
- Inputs prescale and slew_step are sampled live; slew_step is used at each boundary.
- Reset asserted mid-period: outputs go low immediately (asynchronous). After release the first period begins at count 0 with every active ratio at 0.

Decomposition:
- Shared package pwm_pkg: default RATIO_W/PRESCALE_W constants, the ratio full-scale constant (2^RATIO_W-1), and a channel-index width function (clog2).
- Sub-module pwm_channel (one per channel via generate) holds target, active, the slew compare/step, the output register and the done pulse.
- The top level holds the prescaler, the period counter and the write decode.

Test Plan:
- Reset with prescale=0, write ch0=128, slew=0, ch_enable=all ones -> from the second period on, ch0 is high for 128 of every 255 clocks; period_start every 255 clocks; update_done[0] pulses once.
- ch1=0 and ch2=255 -> ch1 constantly low; ch2 constantly high across period boundaries, with no one-clock dip.
- slew_step=32, ch3 target 200 from 0 -> active goes 32,64,96,128,160,192,200 on successive boundaries; update_done[3] pulses only at the 200 boundary.
- Write ch4=100 on the exact boundary clock -> the current period still uses the old ratio; 100 applies one period later.
- Deassert ch_enable[5] mid-high-pulse -> pwm_out[5] low on the next clock; re-enable with slew=50 and target 150 -> ramps 50,100,150.
- wr_addr=NUM_CH (out of range) -> no target changes. prescale=3 -> period is 1020 clocks. Assert reset mid-period -> all outputs 0 asynchronously.
